// File: rtl/btn_step_pkg.sv
// Shared types and sizing helpers for the pushbutton step generator.
// Consumed by btn_debounce and btn_step_gen.
package btn_step_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_t;

  localparam int unsigned DEB_CYC_DEF  = 100000;
  localparam int unsigned HOLD_CYC_DEF = 50000000;
  localparam int unsigned REP_CYC_DEF  = 10000000;

  // Bits needed to hold the value n without wrapping; never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchroniser, stable-level debounce counter and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce
  import btn_step_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = cnt_width(DEB_CYC);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The level flips on the DEB_CYC-th consecutive cycle in which the
  // synchronised input disagrees with it; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CW'(DEB_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/btn_step_gen.sv
// Turns raw up/down/load pushbuttons into single-cycle counter strobes.
// Auto-repeat on a held up/down button is built only with AUTO_REPEAT_EN defined.
module btn_step_gen
  import btn_step_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned REP_CYC  = REP_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_dn_raw,
  input  logic btn_ld_raw,
  output logic up,
  output logic down,
  output logic load,
  output logic repeating
);

  logic   u_lvl;
  logic   u_rise;
  logic   d_lvl;
  logic   d_rise;
  logic   ld_lvl_unused;
  logic   ld_rise;
  logic   act_lvl;
  logic   oth_lvl;

  state_t state_q;
  dir_t   dir_q;
  logic   up_q;
  logic   dn_q;
  logic   ld_q;
  logic   rep_q;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
    .clk_i  (clk),
    .rst_ni (reset),
    .raw_i  (btn_up_raw),
    .level_o(u_lvl),
    .rise_o (u_rise)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dn (
    .clk_i  (clk),
    .rst_ni (reset),
    .raw_i  (btn_dn_raw),
    .level_o(d_lvl),
    .rise_o (d_rise)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ld (
    .clk_i  (clk),
    .rst_ni (reset),
    .raw_i  (btn_ld_raw),
    .level_o(ld_lvl_unused),
    .rise_o (ld_rise)
  );

  assign act_lvl = (dir_q == DIR_UP) ? u_lvl : d_lvl;
  assign oth_lvl = (dir_q == DIR_UP) ? d_lvl : u_lvl;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned CW = cnt_width(max_u(HOLD_CYC, REP_CYC));
  logic [CW-1:0] cnt_q;
`else
  logic unused_params;
  assign unused_params = ^{HOLD_CYC, REP_CYC};
`endif

  // Strobes default low every cycle so each is exactly one cycle wide.
  // A coincident load pulse suppresses the step outright; it is not queued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      ld_q    <= 1'b0;
      rep_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      rep_q <= 1'b0;
      ld_q  <= ld_rise;
      case (state_q)
        IDLE: begin
          if (u_lvl && d_lvl) begin
            state_q <= LOCK;
          end else if (u_rise) begin
            up_q    <= ~ld_rise;
            dir_q   <= DIR_UP;
            state_q <= HOLD;
`ifdef AUTO_REPEAT_EN
            cnt_q   <= '0;
`endif
          end else if (d_rise) begin
            dn_q    <= ~ld_rise;
            dir_q   <= DIR_DN;
            state_q <= HOLD;
`ifdef AUTO_REPEAT_EN
            cnt_q   <= '0;
`endif
          end
        end
        HOLD: begin
          if (!act_lvl) begin
            state_q <= IDLE;
          end else if (oth_lvl) begin
            state_q <= LOCK;
`ifdef AUTO_REPEAT_EN
          end else if (cnt_q >= CW'(HOLD_CYC - 1)) begin
            up_q    <= (dir_q == DIR_UP) && !ld_rise;
            dn_q    <= (dir_q == DIR_DN) && !ld_rise;
            rep_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= REPEAT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        REPEAT: begin
          if (!act_lvl) begin
            state_q <= IDLE;
          end else if (oth_lvl) begin
            state_q <= LOCK;
          end else begin
            rep_q <= 1'b1;
            if (cnt_q >= CW'(REP_CYC - 1)) begin
              up_q  <= (dir_q == DIR_UP) && !ld_rise;
              dn_q  <= (dir_q == DIR_DN) && !ld_rise;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`endif
        LOCK: begin
          if (!u_lvl && !d_lvl) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign up        = up_q;
  assign down      = dn_q;
  assign load      = ld_q;
  assign repeating = rep_q;

endmodule
